// File: rtl/row_derotation_pkg.sv
// Shared constants, FSM encodings and saturation helper for the row derotation CORDIC.
// KINV is the same gain correction the forward normalization stage applies.
package row_derotation_pkg;
  localparam int WL    = 16;
  localparam int FRAC  = 12;
  localparam int ITER  = 12;
  localparam int GUARD = 2;
  localparam int AW    = WL + GUARD;
  localparam int PW    = WL + GUARD + FRAC + 1;
  localparam int IW    = $clog2(ITER);

  // round(2^FRAC / prod(sqrt(1 + 2^-2i))), i = 0..ITER-1
  localparam logic signed [FRAC:0] KINV = 13'sd2487;

  localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (WL - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_LO = PW'(-(1 << (WL - 1)));
  localparam logic signed [PW-1:0] RND    = PW'(1 << (FRAC - 1));

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ITER  = 2'd1;
  localparam logic [1:0] S_SCALE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic signed [WL-1:0] sat_wl(input logic signed [PW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[WL-1:0];
    else if (v < SAT_LO) return SAT_LO[WL-1:0];
    else                 return v[WL-1:0];
  endfunction
endpackage

// File: rtl/row_derotation_if.sv
// Sample/record input handshake and derotated output handshake of row_derotation.
interface row_derotation_if;
  import row_derotation_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [WL-1:0] x_in;
  logic signed [WL-1:0] y_in;
  logic [ITER-1:0]      dir_in;
  logic                 flip_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [WL-1:0] x_out;
  logic signed [WL-1:0] y_out;

  modport master (
    output in_valid, x_in, y_in, dir_in, flip_in, out_ready,
    input  in_ready, out_valid, x_out, y_out
  );

  modport slave (
    input  in_valid, x_in, y_in, dir_in, flip_in, out_ready,
    output in_ready, out_valid, x_out, y_out
  );
endinterface

// File: rtl/row_derotation_micro_rotation.sv
// One inverse CORDIC micro-rotation, combinational; dir=1 undoes a clockwise forward step.
// No state, no handshake.
module derot_micro_rotation
  import row_derotation_pkg::*;
(
  input  logic signed [AW-1:0] x,
  input  logic signed [AW-1:0] y,
  input  logic [IW-1:0]        shift,
  input  logic                 dir,
  output logic signed [AW-1:0] x_nxt,
  output logic signed [AW-1:0] y_nxt
);
  logic signed [AW-1:0] xs;
  logic signed [AW-1:0] ys;

  assign xs = x >>> shift;
  assign ys = y >>> shift;

  always_comb begin
    if (dir) begin
      x_nxt = x - ys;
      y_nxt = y + xs;
    end else begin
      x_nxt = x + ys;
      y_nxt = y - xs;
    end
  end
endmodule

// File: rtl/row_derotation.sv
// Rotates one sample back by its recorded CORDIC angle; out_valid ITER+1 cycles after accept, held until out_ready.
// One sample in flight (in_ready only when idle). Define DEROT_ROUND_EN for round-half-up in the scale step.
module row_derotation
  import row_derotation_pkg::*;
(
  input logic             clk,
  input logic             rst,
  row_derotation_if.slave bus
);
  logic [1:0]           state;
  logic [IW-1:0]        idx;
  logic signed [AW-1:0] x;
  logic signed [AW-1:0] y;
  logic signed [AW-1:0] x_nxt;
  logic signed [AW-1:0] y_nxt;
  logic [ITER-1:0]      dir;
  logic                 flip;
  logic signed [WL-1:0] x_res;
  logic signed [WL-1:0] y_res;
  logic signed [PW-1:0] px;
  logic signed [PW-1:0] py;
  logic signed [PW-1:0] qx;
  logic signed [PW-1:0] qy;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.x_out     = x_res;
  assign bus.y_out     = y_res;

  // Forward iterations are undone last-to-first, so idx counts down.
  derot_micro_rotation u_rot (
    .x     (x),
    .y     (y),
    .shift (idx),
    .dir   (dir[idx]),
    .x_nxt (x_nxt),
    .y_nxt (y_nxt)
  );

  always_comb begin
    px = PW'(x) * PW'(KINV);
    py = PW'(y) * PW'(KINV);
`ifdef DEROT_ROUND_EN
    px = px + RND;
    py = py + RND;
`endif
    qx = px >>> FRAC;
    qy = py >>> FRAC;
    if (flip) begin
      qx = -qx;
      qy = -qy;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      x     <= '0;
      y     <= '0;
      dir   <= '0;
      flip  <= 1'b0;
      x_res <= '0;
      y_res <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x     <= AW'(bus.x_in);
            y     <= AW'(bus.y_in);
            dir   <= bus.dir_in;
            flip  <= bus.flip_in;
            idx   <= IW'(ITER - 1);
            state <= S_ITER;
          end
        end
        S_ITER: begin
          x <= x_nxt;
          y <= y_nxt;
          if (idx == '0) state <= S_SCALE;
          else           idx   <= idx - IW'(1);
        end
        S_SCALE: begin
          x_res <= sat_wl(qx);
          y_res <= sat_wl(qy);
          state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_row_derotation.sv
// Bench for row_derotation: forward-vectoring records fed back and compared with an ideal rotation by the recorded angle.
// Also covers reset, latency, backpressure hold and mid-operation reset.
module tb_row_derotation;
  import row_derotation_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  row_derotation_if bus();
  row_derotation dut (.clk(clk), .rst(rst), .bus(bus));

  int  total = 0;
  int  bad   = 0;
  real gain;
  real kq;
  localparam real TOL = 5.0;

  typedef struct {
    string           name;
    int              ix;
    int              iy;
    logic [ITER-1:0] dirs;
    logic            flip;
    real             ex;
    real             ey;
  } vec_t;
  vec_t vecs[4];

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input real exp);
    real d;
    total++;
    d = real'(act) - exp;
    if (d > TOL || d < -TOL) begin
      bad++;
      $display("FAIL %s: got %0d, want %0.2f (+/-%0.1f)", name, act, exp, TOL);
    end
  endtask

  // Forward stage: negate if x<0, then vector toward the +x axis recording directions.
  function automatic void forward(input int xi, input int yi, output logic [ITER-1:0] d,
                                  output logic f, output int xf);
    int xv, yv, xn;
    f  = (xi < 0);
    xv = f ? -xi : xi;
    yv = f ? -yi : yi;
    d  = '0;
    for (int i = 0; i < ITER; i++) begin
      if (yv >= 0) begin
        d[i] = 1'b1;
        xn   = xv + (yv >>> i);
        yv   = yv - (xv >>> i);
      end else begin
        xn = xv - (yv >>> i);
        yv = yv + (xv >>> i);
      end
      xv = xn;
    end
    xf = xv;
  endfunction

  // Ideal result: exact rotation by the recorded angle, CORDIC gain times quantised KINV, flip, clamp.
  function automatic void ideal(input int xi, input int yi, input logic [ITER-1:0] d,
                                input logic f, output real ex, output real ey);
    real ang, s;
    ang = 0.0;
    for (int i = 0; i < ITER; i++)
      ang = d[i] ? ang + $atan(2.0 ** (-i)) : ang - $atan(2.0 ** (-i));
    s  = gain * kq;
    ex = (real'(xi) * $cos(ang) - real'(yi) * $sin(ang)) * s;
    ey = (real'(xi) * $sin(ang) + real'(yi) * $cos(ang)) * s;
    if (f) begin
      ex = -ex;
      ey = -ey;
    end
    if (ex > 32767.0) ex = 32767.0;
    if (ex < -32768.0) ex = -32768.0;
    if (ey > 32767.0) ey = 32767.0;
    if (ey < -32768.0) ey = -32768.0;
  endfunction

  function automatic void fill(input int k, input string nm, input int fx, input int fy,
                               input int ix, input int iy, input bit use_mag);
    logic [ITER-1:0] d;
    logic            f;
    int              xf;
    real             ex, ey;
    forward(fx, fy, d, f, xf);
    vecs[k].name = nm;
    vecs[k].dirs = d;
    vecs[k].flip = f;
    vecs[k].ix   = use_mag ? int'($floor(real'(xf) * kq)) : ix;
    vecs[k].iy   = iy;
    ideal(vecs[k].ix, vecs[k].iy, d, f, ex, ey);
    vecs[k].ex = ex;
    vecs[k].ey = ey;
  endfunction

  // Present one sample, count posedges from the accept edge to out_valid (bounded).
  task automatic apply(input int xi, input int yi, input logic [ITER-1:0] d, input logic f,
                       output int lat, output int ax, output int ay);
    bit seen;
    @(negedge clk);
    bus.x_in     = WL'(xi);
    bus.y_in     = WL'(yi);
    bus.dir_in   = d;
    bus.flip_in  = f;
    bus.in_valid = 1'b1;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.x_in     = 16'sh5a5a;
      bus.y_in     = -16'sd1234;
      bus.dir_in   = ~d;
      bus.flip_in  = ~f;
      if (bus.out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    ax = int'($signed(bus.x_out));
    ay = int'($signed(bus.y_out));
  endtask

  task automatic release_out(input string nm);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_int({nm, "_valid_drop"}, int'(bus.out_valid), 0);
    check_int({nm, "_ready_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    int lat, ax, ay, glitch, hx, hy;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.dir_in    = '0;
    bus.flip_in   = 1'b0;

    gain = 1.0;
    for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    kq = $floor(real'(1 << FRAC) / gain + 0.5) / real'(1 << FRAC);

    fill(0, "round_trip", 0, 4096, 0, 0, 1'b1);
    fill(1, "flip",       -4096, 0, 4096, 0, 1'b0);
    fill(2, "saturate",   0, 23170, 32767, 32767, 1'b0);
    fill(3, "zero",       0, 0, 0, 0, 1'b1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_int("rst_in_ready",  int'(bus.in_ready), 1);
    check_int("rst_out_valid", int'(bus.out_valid), 0);
    check_int("rst_x_out",     int'($signed(bus.x_out)), 0);
    check_int("rst_y_out",     int'($signed(bus.y_out)), 0);

    for (int k = 0; k < 4; k++) begin
      apply(vecs[k].ix, vecs[k].iy, vecs[k].dirs, vecs[k].flip, lat, ax, ay);
      check_int({vecs[k].name, "_latency"}, lat, ITER + 1);
      check_near({vecs[k].name, "_x"}, ax, vecs[k].ex);
      check_near({vecs[k].name, "_y"}, ay, vecs[k].ey);
      release_out(vecs[k].name);
    end

    // Backpressure: result and flags frozen for 20 cycles while a new input is offered.
    apply(vecs[0].ix, vecs[0].iy, vecs[0].dirs, vecs[0].flip, lat, ax, ay);
    check_int("bp_latency", lat, ITER + 1);
    hx = ax;
    hy = ay;
    bus.in_valid = 1'b1;
    bus.x_in     = 16'sd1000;
    glitch       = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready ||
          int'($signed(bus.x_out)) != hx || int'($signed(bus.y_out)) != hy) glitch++;
    end
    bus.in_valid = 1'b0;
    check_int("bp_hold_glitches", glitch, 0);
    release_out("bp");

    // Reset in the middle of iterating drops the sample and clears the output registers.
    @(negedge clk);
    bus.x_in     = WL'(vecs[0].ix);
    bus.y_in     = WL'(vecs[0].iy);
    bus.dir_in   = vecs[0].dirs;
    bus.flip_in  = vecs[0].flip;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_int("mid_rst_in_ready",  int'(bus.in_ready), 1);
    check_int("mid_rst_out_valid", int'(bus.out_valid), 0);
    check_int("mid_rst_x_out",     int'($signed(bus.x_out)), 0);
    glitch = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) glitch++;
    end
    check_int("mid_rst_no_valid", glitch, 0);
    apply(vecs[0].ix, vecs[0].iy, vecs[0].dirs, vecs[0].flip, lat, ax, ay);
    check_int("post_rst_latency", lat, ITER + 1);
    check_near("post_rst_x", ax, vecs[0].ex);
    check_near("post_rst_y", ay, vecs[0].ey);
    release_out("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
